// File: rtl/key_mode_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : key_mode_ctrl_if
// Description : Key pins in, per-key pulses and mode selection out. The board
//               side (master) drives the raw keys; the key front-end (slave)
//               drives the pulses and the wave mode selection.
// Revision    : 1.0 - initial release
// ============================================================================
interface key_mode_ctrl_if #(
    parameter int NUM_KEYS = 4,
    parameter int IDX_W    = 2
);
    logic [NUM_KEYS-1:0] key;
    logic [NUM_KEYS-1:0] key_press;
    logic [NUM_KEYS-1:0] key_long;
    logic [NUM_KEYS-1:0] key_repeat;
    logic [NUM_KEYS-1:0] wave_select;
    logic [IDX_W-1:0]    wave_idx;
    logic                sel_changed;

    modport master (
        output key,
        input  key_press,
        input  key_long,
        input  key_repeat,
        input  wave_select,
        input  wave_idx,
        input  sel_changed
    );

    modport slave (
        input  key,
        output key_press,
        output key_long,
        output key_repeat,
        output wave_select,
        output wave_idx,
        output sel_changed
    );
endinterface
`default_nettype wire

// File: rtl/key_mode_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : key_mode_ctrl
// Description : Debounces NUM_KEYS active-low buttons (one FSM per key), emits
//               press / long-press / auto-repeat pulses, and keeps a one-hot
//               wave mode selection with its binary index.
// Revision    : 1.0 - initial release
// ============================================================================
module key_mode_ctrl #(
    parameter int NUM_KEYS   = 4,
    parameter int CNT_MAX    = 999_999,
    parameter int LONG_MAX   = 49_999_999,
    parameter int REPEAT_MAX = 9_999_999,
    parameter int IDX_W      = 2
) (
    input  wire logic      sys_clk,
    input  wire logic      sys_rst_n,
    key_mode_ctrl_if.slave bus
);

    // One shared counter width per key, sized for the longest terminal count.
    localparam int c_MAX_AB   = (CNT_MAX > LONG_MAX) ? CNT_MAX : LONG_MAX;
    localparam int c_MAX_TERM = (c_MAX_AB > REPEAT_MAX) ? c_MAX_AB : REPEAT_MAX;
    localparam int c_CNT_W    = (c_MAX_TERM > 0) ? $clog2(c_MAX_TERM + 1) : 1;

    localparam logic [c_CNT_W-1:0] c_CNT_TERM    = c_CNT_W'(CNT_MAX);
    localparam logic [c_CNT_W-1:0] c_LONG_TERM   = c_CNT_W'(LONG_MAX);
    localparam logic [c_CNT_W-1:0] c_REPEAT_TERM = c_CNT_W'(REPEAT_MAX);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE     = c_CNT_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PRESS_DB = 3'd1,
        ST_HELD     = 3'd2,
        ST_REPEAT   = 3'd3,
        ST_REL_DB   = 3'd4
    } state_t;

    logic [NUM_KEYS-1:0] r_sync1;
    logic [NUM_KEYS-1:0] r_sync2;
    logic [NUM_KEYS-1:0] w_press;
    logic [NUM_KEYS-1:0] w_long;
    logic [NUM_KEYS-1:0] w_repeat;

    logic [NUM_KEYS-1:0] w_win_sel;
    logic [IDX_W-1:0]    w_win_idx;
    logic                w_any_press;

    logic [NUM_KEYS-1:0] r_sel;
    logic [IDX_W-1:0]    r_idx;
    logic                r_sel_chg;

    // Two-flop synchronizer; resets to released (1) so no phantom press on reset.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
        end else begin
            r_sync1 <= bus.key;
            r_sync2 <= r_sync1;
        end
    end

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        state_t               r_state;
        logic [c_CNT_W-1:0]   r_cnt;
        logic                 r_press;
        logic                 r_long;
        logic                 r_repeat;
        logic                 w_key_s;

        assign w_key_s     = r_sync2[i];
        assign w_press[i]  = r_press;
        assign w_long[i]   = r_long;
        assign w_repeat[i] = r_repeat;

        // Per-key debounce / hold / repeat FSM with registered pulse outputs.
        always_ff @(posedge sys_clk or negedge sys_rst_n) begin
            if (!sys_rst_n) begin
                r_state  <= ST_IDLE;
                r_cnt    <= '0;
                r_press  <= 1'b0;
                r_long   <= 1'b0;
                r_repeat <= 1'b0;
            end else begin
                r_press  <= 1'b0;
                r_long   <= 1'b0;
                r_repeat <= 1'b0;
                case (r_state)
                    ST_IDLE: begin
                        if (!w_key_s) begin
                            r_state <= ST_PRESS_DB;
                            r_cnt   <= '0;
                        end
                    end
                    ST_PRESS_DB: begin
                        if (w_key_s) begin
                            r_state <= ST_IDLE;
                            r_cnt   <= '0;
                        end else if (r_cnt == c_CNT_TERM) begin
                            r_state <= ST_HELD;
                            r_cnt   <= '0;
                            r_press <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + c_CNT_ONE;
                        end
                    end
                    ST_HELD: begin
                        if (w_key_s) begin
                            r_state <= ST_REL_DB;
                            r_cnt   <= '0;
                        end else if (r_cnt == c_LONG_TERM) begin
                            r_state <= ST_REPEAT;
                            r_cnt   <= '0;
                            r_long  <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + c_CNT_ONE;
                        end
                    end
                    ST_REPEAT: begin
                        if (w_key_s) begin
                            r_state <= ST_REL_DB;
                            r_cnt   <= '0;
                        end else if (r_cnt == c_REPEAT_TERM) begin
                            r_cnt    <= '0;
                            r_repeat <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + c_CNT_ONE;
                        end
                    end
                    ST_REL_DB: begin
                        // A bounce back to low resumes the hold without a new
                        // press; long-press timing starts over.
                        if (!w_key_s) begin
                            r_state <= ST_HELD;
                            r_cnt   <= '0;
                        end else if (r_cnt == c_CNT_TERM) begin
                            r_state <= ST_IDLE;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt + c_CNT_ONE;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                    end
                endcase
            end
        end
    end

    // Lowest-index pressed key wins when several presses coincide.
    always_comb begin
        w_win_sel = '0;
        w_win_idx = '0;
        for (int k = NUM_KEYS - 1; k >= 0; k--) begin
            if (w_press[k]) begin
                w_win_sel    = '0;
                w_win_sel[k] = 1'b1;
                w_win_idx    = IDX_W'(k);
            end
        end
    end

    assign w_any_press = |w_press;

    // Mode register: updates one cycle after a press, flags real changes only.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_sel     <= '0;
            r_idx     <= '0;
            r_sel_chg <= 1'b0;
        end else if (w_any_press) begin
            r_sel     <= w_win_sel;
            r_idx     <= w_win_idx;
            r_sel_chg <= (w_win_sel != r_sel);
        end else begin
            r_sel_chg <= 1'b0;
        end
    end

    assign bus.key_press   = w_press;
    assign bus.key_long    = w_long;
    assign bus.key_repeat  = w_repeat;
    assign bus.wave_select = r_sel;
    assign bus.wave_idx    = r_idx;
    assign bus.sel_changed = r_sel_chg;

endmodule
`default_nettype wire
